adder_share_arb: RTL and testbench
==================================

Name: adder_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one 2-step pipelined 8-bit adder between NREQ requesters.
- Accepts at most one add request per cycle, drives the adder operand/carry-in bus, and tracks a requester tag through a LAT-deep valid/tag pipeline.
- Returns each sum/carry to its originator with an ID on a shared result bus.
- Sits between issuing units (ALU/address-gen clients) and the adder instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width; must match the adder.
- LAT, 2, adder latency in clock edges from operand presentation to valid sum/cout.
- IDW, 2, tag width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; held high with operands stable until granted.
- req_a  in  NREQ*WIDTH  packed operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed operand B, same packing.
- req_cin  in  NREQ  per-requester carry-in.
- gnt  out  NREQ  one-hot grant; combinational, same cycle as accept.
- flush  in  1  synchronous kill of all in-flight operations.
- add_a  out  WIDTH  to adder cin_a.
- add_b  out  WIDTH  to adder cin_b.
- add_cin  out  1  to adder cin.
- add_sum  in  WIDTH  from adder sum.
- add_cout  in  1  from adder cout.
- res_valid  out  1  result strobe, one cycle.
- res_id  out  IDW  requester index of the result.
- res_sum  out  WIDTH  result sum, equals add_sum.
- res_cout  out  1  result carry, equals add_cout.
- busy  out  1  high while any valid bit is set in the tag pipeline.

Behaviour:
- Reset (async, rst=1): round-robin pointer = 0; valid/tag pipeline cleared; res_valid=0, res_id=0, busy=0.
  - gnt=0 while rst is high; add_a/add_b/add_cin = 0 while idle.
- Arbitration:
  - Search order starts at the pointer and wraps modulo NREQ; the first i with req[i]=1 gets gnt[i]=1.
  - Accept = |gnt. On accept, pointer <= granted index + 1, wrapping NREQ-1 -> 0. With no request, the pointer holds.
  - flush=1 suppresses gnt in that cycle.
- Issue:
  - When granted i, add_a/add_b/add_cin = slice i of req_a/req_b/req_cin, same cycle (combinational mux).
  - With no grant, drive 0 on add_a/add_b/add_cin.
- Tag pipeline:
  - LAT stages of {valid, id}. Stage 0 loads {accept, granted index} at each edge; stage k loads stage k-1.
  - The pipeline advances every cycle; the adder has no stall.
- Result:
  - res_valid = last-stage valid; res_id = last-stage id; res_sum/res_cout pass add_sum/add_cout through.
  - Latency: request granted in cycle T -> res_valid high in cycle T+LAT.
  - Throughput: 1 result per cycle; no result backpressure (consumers always accept).
- flush:
  - At the edge where flush=1, all valid bits <= 0, so no res_valid for anything in flight or issued that cycle.
  - Pointer unchanged.
- Fairness and hold rules:
  - A requester held high with all others high is granted once every NREQ cycles.
  - Dropping req before grant withdraws the request; no penalty.
- Mid-operation reset: in-flight results are discarded and never reported; the pointer returns to 0.
- busy = OR of all pipeline valid bits (registered state only).

Optional Feature:
- Macro ADDARB_PERF_EN.
- Defined: adds outputs perf_issue[15:0] and perf_conflict[15:0], both reset to 0.
  - perf_issue increments on each accept.
  - perf_conflict increments on each cycle where popcount(req) >= 2.
  - Both saturate at 16'hFFFF; flush does not clear them.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Single request: req=4'b0001, a=8'h3C, b=8'h55, cin=0 in cycle T -> gnt=0001 in T; res_valid in T+2 with id=0, sum=8'h91, cout=0.
- Carry chain: requester 2, a=8'hFF, b=8'h00, cin=1 -> id=2, sum=8'h00, cout=1, two cycles after grant.
- All four requesting continuously from reset -> grants 0,1,2,3,0,...; back-to-back res_valid with ids 0,1,2,3 starting 2 cycles after the first grant.
- Pointer skip: pointer at 1, req=4'b1001 -> gnt=1000, then pointer=0 -> next grant 0001.
- Flush: grants in T and T+1, flush=1 at T+1 -> no res_valid in T+2 or T+3; busy=0 at T+2.
- Async reset at T+1 after a grant at T -> res_valid never asserts for it; the next grant goes to requester 0 first.

Source files
------------

// File: rtl/adder_share_arb_if.sv
// adder_share_arb_if: request, adder and result bus between the requesters,
// the shared adder and the arbiter.
// master: the requester/adder side. slave: the arbiter.
interface adder_share_arb_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic [NREQ-1:0]       gnt;
    logic                  flush;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  add_cin;
    logic [WIDTH-1:0]      add_sum;
    logic                  add_cout;
    logic                  res_valid;
    logic [IDW-1:0]        res_id;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_cout;
    logic                  busy;

    modport master (
        output req, req_a, req_b, req_cin, flush, add_sum, add_cout,
        input  gnt, add_a, add_b, add_cin, res_valid, res_id, res_sum, res_cout, busy
    );

    modport slave (
        input  req, req_a, req_b, req_cin, flush, add_sum, add_cout,
        output gnt, add_a, add_b, add_cin, res_valid, res_id, res_sum, res_cout, busy
    );
endinterface

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin arbiter that shares one LAT-cycle pipelined
// adder between NREQ requesters and routes each result back with its id.
// Optional macro ADDARB_PERF_EN adds saturating perf_issue/perf_conflict
// counters.
module adder_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int LAT   = 2,
    parameter int IDW   = 2
) (
    input  logic clk,
    input  logic rst,
    adder_share_arb_if.slave bus
`ifdef ADDARB_PERF_EN
    ,
    output logic [15:0] perf_issue,
    output logic [15:0] perf_conflict
`endif
);
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;
    logic [NREQ-1:0] gnt_c;
    logic [IDW-1:0]  gidx_c;
    logic            accept_c;
    logic [LAT-1:0]  vld_q;
    logic [IDW-1:0]  id_q [LAT];

    // Round-robin pick: first requester at or above the pointer, else the
    // first one below it (wrap). Reset and flush suppress the grant.
    always_comb begin
        gnt_c    = '0;
        gidx_c   = '0;
        accept_c = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!accept_c && bus.req[i] && (IDW'(i) >= ptr_q)) begin
                accept_c = 1'b1;
                gnt_c[i] = 1'b1;
                gidx_c   = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!accept_c && bus.req[i] && (IDW'(i) < ptr_q)) begin
                accept_c = 1'b1;
                gnt_c[i] = 1'b1;
                gidx_c   = IDW'(i);
            end
        end
        if (rst || bus.flush) begin
            gnt_c    = '0;
            accept_c = 1'b0;
        end
    end

    // Pointer moves to one past the winner; holds when nothing is accepted.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_c) begin
            ptr_d = (gidx_c == IDW'(NREQ - 1)) ? '0 : gidx_c + IDW'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Operand mux: one-hot grant selects the slice, zero when idle.
    always_comb begin
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.add_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                bus.add_a   = bus.add_a | bus.req_a[i*WIDTH +: WIDTH];
                bus.add_b   = bus.add_b | bus.req_b[i*WIDTH +: WIDTH];
                bus.add_cin = bus.add_cin | bus.req_cin[i];
            end
        end
    end

    // Tag pipeline: runs in lockstep with the adder, flush kills every stage.
    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // Head stage captures this cycle's accept and winner id.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        vld_q[0] <= 1'b0;
                        id_q[0]  <= '0;
                    end else begin
                        vld_q[0] <= accept_c && !bus.flush;
                        id_q[0]  <= gidx_c;
                    end
                end
            end else begin : g_body
                // Later stages shift the previous stage along.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        vld_q[gi] <= 1'b0;
                        id_q[gi]  <= '0;
                    end else begin
                        vld_q[gi] <= vld_q[gi-1] && !bus.flush;
                        id_q[gi]  <= id_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign bus.gnt       = gnt_c;
    assign bus.res_valid = vld_q[LAT-1];
    assign bus.res_id    = id_q[LAT-1];
    assign bus.res_sum   = bus.add_sum;
    assign bus.res_cout  = bus.add_cout;
    assign bus.busy      = |vld_q;

`ifdef ADDARB_PERF_EN
    logic [15:0] perf_issue_q;
    logic [15:0] perf_conflict_q;

    // Saturating issue and contention counters; flush leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_q    <= '0;
            perf_conflict_q <= '0;
        end else begin
            if (accept_c && (perf_issue_q != 16'hFFFF)) begin
                perf_issue_q <= perf_issue_q + 16'd1;
            end
            if (($countones(bus.req) >= 2) && (perf_conflict_q != 16'hFFFF)) begin
                perf_conflict_q <= perf_conflict_q + 16'd1;
            end
        end
    end

    assign perf_issue    = perf_issue_q;
    assign perf_conflict = perf_conflict_q;
`endif
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: directed bench with a two-stage adder model and a
// scoreboard of expected results keyed by the cycle they are due.
module tb_adder_share_arb;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int LAT   = 2;
    localparam int IDW   = 2;

    typedef struct {
        int         due;
        logic [1:0] id;
        logic [7:0] sum;
        logic       cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sbq[$];

    logic [7:0] op_a [NREQ];
    logic [7:0] op_b [NREQ];
    logic       op_cin [NREQ];
    logic [8:0] s1 = '0;
    logic [8:0] s2 = '0;

    adder_share_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) ifc ();

`ifdef ADDARB_PERF_EN
    logic [15:0] perf_issue;
    logic [15:0] perf_conflict;
    int exp_issue = 0;
    int exp_conf = 0;
`endif

    adder_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
`ifdef ADDARB_PERF_EN
        ,
        .perf_issue    (perf_issue),
        .perf_conflict (perf_conflict)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared adder model: sum appears two edges after the operands.
    always @(posedge clk) begin
        s1 <= {1'b0, ifc.add_a} + {1'b0, ifc.add_b} + {8'd0, ifc.add_cin};
        s2 <= s1;
    end
    assign ifc.add_sum  = s2[7:0];
    assign ifc.add_cout = s2[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic pack_ops();
        for (int i = 0; i < NREQ; i++) begin
            ifc.req_a[i*WIDTH +: WIDTH] = op_a[i];
            ifc.req_b[i*WIDTH +: WIDTH] = op_b[i];
            ifc.req_cin[i]              = op_cin[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i]   = 8'($urandom_range(0, 255));
            op_b[i]   = 8'($urandom_range(0, 255));
            op_cin[i] = 1'($urandom_range(0, 1));
        end
    endtask

    // One cycle: drive request/flush, check grant and adder bus, and queue
    // the result if this grant is expected to survive.
    task automatic step(input logic [3:0] r, input logic fl, input logic [3:0] eg, input bit keep);
        int         idx;
        logic [16:0] exp_bus;
        logic [8:0]  s;
        exp_t        e;
        @(negedge clk);
        ifc.req   = r;
        ifc.flush = fl;
        pack_ops();
        #1;
        chk("gnt", 32'(ifc.gnt), 32'(eg));
        idx = 0;
        for (int i = 0; i < NREQ; i++) if (eg[i]) idx = i;
        exp_bus = (eg != 4'b0) ? {op_cin[idx], op_b[idx], op_a[idx]} : 17'd0;
        chk("add_bus", 32'({ifc.add_cin, ifc.add_b, ifc.add_a}), 32'(exp_bus));
        s = {1'b0, op_a[idx]} + {1'b0, op_b[idx]} + {8'd0, op_cin[idx]};
        if (keep && eg != 4'b0) begin
            e.due  = cyc + LAT;
            e.id   = 2'(idx);
            e.sum  = s[7:0];
            e.cout = s[8];
            sbq.push_back(e);
            $display("issue id=%0d a=%02h b=%02h cin=%0b due=%0d", idx, op_a[idx], op_b[idx], op_cin[idx], e.due);
        end
`ifdef ADDARB_PERF_EN
        if (eg != 4'b0) exp_issue++;
        if ($countones(r) >= 2) exp_conf++;
`endif
    endtask

    // Result monitor: every cycle, either the queued result is due now or
    // res_valid must be low.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                chk("res_valid", 32'(ifc.res_valid), 32'd1);
                chk("res_id", 32'(ifc.res_id), 32'(e.id));
                chk("res_sum", 32'(ifc.res_sum), 32'(e.sum));
                chk("res_cout", 32'(ifc.res_cout), 32'(e.cout));
                $display("result id=%0d sum=%02h cout=%0b cycle=%0d", ifc.res_id, ifc.res_sum, ifc.res_cout, cyc);
            end else begin
                chk("res_unexpected", 32'(ifc.res_valid), 32'd0);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        ifc.req   = 4'hF;
        ifc.flush = 1'b0;
        rand_ops();
        pack_ops();

        // Reset state: nothing granted even with all requesting.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", 32'(ifc.gnt), 32'd0);
        chk("rst_res_valid", 32'(ifc.res_valid), 32'd0);
        chk("rst_res_id", 32'(ifc.res_id), 32'd0);
        chk("rst_busy", 32'(ifc.busy), 32'd0);
        chk("rst_add_bus", 32'({ifc.add_cin, ifc.add_b, ifc.add_a}), 32'd0);
        ifc.req = 4'h0;
        rst     = 1'b0;

        // All four requesting: strict rotation 0,1,2,3,0,1,2,3.
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            step(4'hF, 1'b0, 4'(1 << (k % 4)), 1'b1);
        end
        step(4'h0, 1'b0, 4'h0, 1'b0);
        step(4'h0, 1'b0, 4'h0, 1'b0);

        // Single request from requester 0 (pointer back at 0): sum 91.
        op_a[0] = 8'h3C; op_b[0] = 8'h55; op_cin[0] = 1'b0;
        step(4'b0001, 1'b0, 4'b0001, 1'b1);
        // Carry chain through requester 2: FF+00+1.
        op_a[2] = 8'hFF; op_b[2] = 8'h00; op_cin[2] = 1'b1;
        step(4'b0100, 1'b0, 4'b0100, 1'b1);
        step(4'h0, 1'b0, 4'h0, 1'b0);
        step(4'h0, 1'b0, 4'h0, 1'b0);
        step(4'h0, 1'b0, 4'h0, 1'b0);
        chk("busy_drained", 32'(ifc.busy), 32'd0);

        // Pointer skip and wrap (pointer is 3 here).
        rand_ops();
        step(4'b1000, 1'b0, 4'b1000, 1'b1);
        step(4'b0001, 1'b0, 4'b0001, 1'b1);
        step(4'b1001, 1'b0, 4'b1000, 1'b1);
        step(4'b1001, 1'b0, 4'b0001, 1'b1);
        step(4'h0, 1'b0, 4'h0, 1'b0);
        step(4'h0, 1'b0, 4'h0, 1'b0);

        // Flush (pointer is 1): grant at T, flush at T+1 kills both.
        rand_ops();
        step(4'b0010, 1'b0, 4'b0010, 1'b0);
        step(4'b0100, 1'b1, 4'b0000, 1'b0);
        step(4'h0, 1'b0, 4'h0, 1'b0);
        chk("flush_res_t2", 32'(ifc.res_valid), 32'd0);
        chk("flush_busy_t2", 32'(ifc.busy), 32'd0);
        step(4'h0, 1'b0, 4'h0, 1'b0);
        chk("flush_res_t3", 32'(ifc.res_valid), 32'd0);
        // Pointer untouched by the flushed cycle: still 2.
        step(4'b0110, 1'b0, 4'b0100, 1'b1);
        step(4'h0, 1'b0, 4'h0, 1'b0);
        step(4'h0, 1'b0, 4'h0, 1'b0);

        // Async reset mid-flight (pointer is 3): grant to 1, then reset.
        rand_ops();
        step(4'b0010, 1'b0, 4'b0010, 1'b0);
        @(negedge clk);
        ifc.req = 4'h0;
        #2;
        rst = 1'b1;
        ifc.req = 4'hF;
        #1;
        chk("arst_busy", 32'(ifc.busy), 32'd0);
        chk("arst_res_valid", 32'(ifc.res_valid), 32'd0);
        chk("arst_gnt", 32'(ifc.gnt), 32'd0);
        @(negedge clk);
        ifc.req = 4'h0;
        rst     = 1'b0;
`ifdef ADDARB_PERF_EN
        exp_issue = 0;
        exp_conf  = 0;
`endif
        step(4'hF, 1'b0, 4'b0001, 1'b1);
        step(4'hF, 1'b0, 4'b0010, 1'b1);
        for (int k = 0; k < 4; k++) step(4'h0, 1'b0, 4'h0, 1'b0);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        chk("end_busy", 32'(ifc.busy), 32'd0);
`ifdef ADDARB_PERF_EN
        chk("perf_issue", 32'(perf_issue), 32'(exp_issue));
        chk("perf_conflict", 32'(perf_conflict), 32'(exp_conf));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
